// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: counter states,
// table entry layout and saturation limits.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_state_t;

  localparam int ADDR_W = 32;

  // Tag and target are held zero-extended to the full address width.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] tag;
    ctr_state_t        ctr;
    logic [ADDR_W-1:0] target;
  } bp_entry_t;

  localparam ctr_state_t CTR_MIN       = SNT;
  localparam ctr_state_t CTR_MAX       = ST;
  localparam ctr_state_t CTR_RESET     = WNT;
  localparam ctr_state_t CTR_ALLOC_BR  = WT;
  localparam ctr_state_t CTR_ALLOC_JMP = ST;

  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  localparam bp_entry_t ENTRY_RESET = '{
    valid:  1'b0,
    tag:    '0,
    ctr:    CTR_RESET,
    target: '0
  };

  function automatic logic [31:0] stat_inc(input logic [31:0] value);
    return (value == STAT_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for the 2-bit saturating direction counter; jumps force
// the strongly-taken state.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  input  logic       force_st,
  output logic [1:0] next_state
);

  always_comb begin
    next_state = state;
    if (force_st) begin
      next_state = CTR_MAX;
    end else if (taken) begin
      if (state != CTR_MAX) next_state = state + 2'd1;
    end else begin
      if (state != CTR_MIN) next_state = state - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped branch predictor with BTB targets, EX-stage resolution,
// mispredict/redirect generation and saturating statistics.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  input  logic            res_valid,
  input  logic            res_is_branch,
  input  logic            res_is_jump,
  input  logic            res_taken,
  input  logic [PC_W-1:0] res_pc,
  input  logic [31:0]     res_target,
  input  logic            res_pred_taken,
  input  logic [31:0]     res_pred_target,
  output logic            mispredict,
  output logic [31:0]     redirect_pc,
  input  logic            stats_clr,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  bp_entry_t table_q [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] res_idx;
  logic [TAG_W-1:0] res_tag;
  bp_entry_t        fetch_entry;
  bp_entry_t        res_entry;
  bp_entry_t        entry_next;
  logic             fetch_hit;
  logic             res_hit;
  logic             resolve;
  logic             upd_en;
  logic [1:0]       ctr_next;
  logic [PC_W-1:0]  fetch_seq;
  logic [PC_W-1:0]  res_seq;
  logic [31:0]      br_count_reg;
  logic [31:0]      mispred_count_reg;

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign fetch_tag = fetch_pc[PC_W-1:IDX_W+2];
  assign res_idx   = res_pc[IDX_W+1:2];
  assign res_tag   = res_pc[PC_W-1:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update is not seen.
  assign fetch_entry = table_q[fetch_idx];
  assign fetch_hit   = fetch_entry.valid && (fetch_entry.tag == ADDR_W'(fetch_tag));
  assign pred_taken  = fetch_hit && fetch_entry.ctr[1];
  assign fetch_seq   = fetch_pc + PC_W'(4);
  assign pred_target = pred_taken ? fetch_entry.target : ADDR_W'(fetch_seq);

  assign resolve    = res_valid && (res_is_branch || res_is_jump);
  assign mispredict = resolve && ((res_taken != res_pred_taken) ||
                                  (res_taken && (res_target != res_pred_target)));
  assign res_seq     = res_pc + PC_W'(4);
  assign redirect_pc = !mispredict ? 32'd0 :
                       res_taken   ? res_target : ADDR_W'(res_seq);

  assign res_entry = table_q[res_idx];
  assign res_hit   = res_entry.valid && (res_entry.tag == ADDR_W'(res_tag));

  bp_sat_counter u_sat_counter (
    .state      (res_entry.ctr),
    .taken      (res_taken),
    .force_st   (res_is_jump),
    .next_state (ctr_next)
  );

  always_comb begin
    entry_next = res_entry;
    upd_en     = 1'b0;
    if (resolve) begin
      if (res_hit) begin
        upd_en         = 1'b1;
        entry_next.ctr = ctr_state_t'(ctr_next);
        if (res_taken) entry_next.target = ADDR_W'(res_target[PC_W-1:0]);
      end else if (res_taken) begin
        // Direct-mapped: a taken miss replaces whatever lives at this index.
        upd_en            = 1'b1;
        entry_next.valid  = 1'b1;
        entry_next.tag    = ADDR_W'(res_tag);
        entry_next.ctr    = res_is_jump ? CTR_ALLOC_JMP : CTR_ALLOC_BR;
        entry_next.target = ADDR_W'(res_target[PC_W-1:0]);
      end
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    bp_entry_t entry_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_reg <= ENTRY_RESET;
      end else if (upd_en && (res_idx == IDX_W'(gi))) begin
        entry_reg <= entry_next;
      end
    end

    assign table_q[gi] = entry_reg;
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_reg      <= 32'd0;
      mispred_count_reg <= 32'd0;
    end else if (stats_clr) begin
      br_count_reg      <= 32'd0;
      mispred_count_reg <= 32'd0;
    end else begin
      if (resolve)    br_count_reg      <= stat_inc(br_count_reg);
      if (mispredict) mispred_count_reg <= stat_inc(mispred_count_reg);
    end
  end

  assign br_count      = br_count_reg;
  assign mispred_count = mispred_count_reg;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit (PC_W=9, ENTRIES=16) with
// hand-computed expectations.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid, res_is_branch, res_is_jump, res_taken;
  logic [8:0]  res_pc;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        stats_clr;
  logic [31:0] br_count, mispred_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_pc        (fetch_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .res_valid       (res_valid),
    .res_is_branch   (res_is_branch),
    .res_is_jump     (res_is_jump),
    .res_taken       (res_taken),
    .res_pc          (res_pc),
    .res_target      (res_target),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .stats_clr       (stats_clr),
    .br_count        (br_count),
    .mispred_count   (mispred_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic [8:0] pc,
                        input logic exp_t, input logic [31:0] exp_tgt);
    fetch_pc = pc;
    #1;
    chk({tag, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
    chk({tag, ".pred_target"}, pred_target, exp_tgt);
  endtask

  task automatic stats(input string tag, input logic [31:0] exp_br, input logic [31:0] exp_mp);
    chk({tag, ".br_count"}, br_count, exp_br);
    chk({tag, ".mispred_count"}, mispred_count, exp_mp);
  endtask

  task automatic resolve(input string tag, input logic vld, input logic [8:0] pc,
                         input logic br, input logic jmp, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                         input logic exp_mis, input logic [31:0] exp_red);
    @(negedge clk);
    res_valid = vld; res_pc = pc; res_is_branch = br; res_is_jump = jmp;
    res_taken = tk; res_target = tgt; res_pred_taken = ptk; res_pred_target = ptgt;
    #1;
    chk({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, exp_mis});
    chk({tag, ".redirect_pc"}, redirect_pc, exp_red);
    $display("resolve %s: pc=%h br=%b jmp=%b taken=%b mispredict=%b redirect=%h",
             tag, pc, br, jmp, tk, mispredict, redirect_pc);
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fetch_pc = 9'h040; stats_clr = 1'b0;
    res_valid = 0; res_is_branch = 0; res_is_jump = 0; res_taken = 0;
    res_pc = '0; res_target = '0; res_pred_taken = 0; res_pred_target = '0;
    #2;
    lookup("rst", 9'h040, 1'b0, 32'h044);
    stats("rst", 0, 0);
    @(negedge clk); rst_n = 1'b1;

    // Allocate a taken branch, then walk its counter.
    resolve("s1", 1, 9'h040, 1, 0, 1, 32'h010, 0, 32'h044, 1, 32'h010);
    lookup("s1", 9'h040, 1'b1, 32'h010);
    stats("s1", 1, 1);
    resolve("s2", 1, 9'h040, 1, 0, 0, 32'h000, 1, 32'h010, 1, 32'h044);
    lookup("s2", 9'h040, 1'b0, 32'h044);
    resolve("s3", 1, 9'h040, 1, 0, 0, 32'h000, 0, 32'h044, 0, 32'h000);
    resolve("s4", 1, 9'h040, 1, 0, 1, 32'h010, 0, 32'h044, 1, 32'h010);
    lookup("s4", 9'h040, 1'b0, 32'h044);
    resolve("s5", 1, 9'h040, 1, 0, 1, 32'h010, 0, 32'h044, 1, 32'h010);
    lookup("s5", 9'h040, 1'b1, 32'h010);
    resolve("s6", 1, 9'h040, 1, 0, 1, 32'h010, 1, 32'h010, 0, 32'h000);
    resolve("s7", 1, 9'h040, 1, 0, 1, 32'h010, 1, 32'h010, 0, 32'h000);
    resolve("s8", 1, 9'h040, 1, 0, 0, 32'h000, 1, 32'h010, 1, 32'h044);
    lookup("s8_sat", 9'h040, 1'b1, 32'h010);
    resolve("s9", 1, 9'h040, 1, 0, 0, 32'h000, 1, 32'h010, 1, 32'h044);
    lookup("s9", 9'h040, 1'b0, 32'h044);
    resolve("s10", 1, 9'h040, 1, 0, 1, 32'h020, 0, 32'h044, 1, 32'h020);
    lookup("s10", 9'h040, 1'b1, 32'h020);
    resolve("s11_tgt", 1, 9'h040, 1, 0, 1, 32'h020, 1, 32'h010, 1, 32'h020);
    resolve("nonbr", 1, 9'h040, 0, 0, 1, 32'h030, 0, 32'h044, 0, 32'h000);
    resolve("novalid", 0, 9'h040, 1, 0, 1, 32'h030, 0, 32'h044, 0, 32'h000);
    stats("s11", 11, 8);
    lookup("nonbr", 9'h040, 1'b1, 32'h020);

    // Jump at 0x080 aliases index 0 and evicts 0x040.
    resolve("j1", 1, 9'h080, 0, 1, 1, 32'h100, 0, 32'h084, 1, 32'h100);
    lookup("j1", 9'h080, 1'b1, 32'h100);
    lookup("j1_evict", 9'h040, 1'b0, 32'h044);
    resolve("b1", 1, 9'h080, 1, 0, 0, 32'h000, 1, 32'h100, 1, 32'h084);
    lookup("b1", 9'h080, 1'b1, 32'h100);
    resolve("b2", 1, 9'h080, 1, 0, 0, 32'h000, 1, 32'h100, 1, 32'h084);
    lookup("b2", 9'h080, 1'b0, 32'h084);
    resolve("j2", 1, 9'h080, 0, 1, 1, 32'h100, 0, 32'h084, 1, 32'h100);
    resolve("b3", 1, 9'h080, 1, 0, 0, 32'h000, 1, 32'h100, 1, 32'h084);
    lookup("b3_force", 9'h080, 1'b1, 32'h100);
    stats("b3", 16, 13);

    // Aliasing eviction and not-taken miss.
    resolve("c0", 1, 9'h0C0, 1, 0, 1, 32'h030, 0, 32'h0C4, 1, 32'h030);
    lookup("c0", 9'h0C0, 1'b1, 32'h030);
    lookup("c0_evict", 9'h080, 1'b0, 32'h084);
    resolve("ntmiss", 1, 9'h040, 1, 0, 0, 32'h000, 0, 32'h044, 0, 32'h000);
    lookup("ntmiss", 9'h0C0, 1'b1, 32'h030);

    // Same-cycle lookup and update of the same index sees old contents.
    @(negedge clk);
    fetch_pc = 9'h0C0;
    res_valid = 1; res_pc = 9'h0C0; res_is_branch = 1; res_is_jump = 0;
    res_taken = 1; res_target = 32'h038; res_pred_taken = 1; res_pred_target = 32'h030;
    #1;
    chk("same.pred_target", pred_target, 32'h030);
    chk("same.mispredict", {31'd0, mispredict}, 32'd1);
    $display("resolve same: pc=0c0 taken=1 pred_target=%h", pred_target);
    @(posedge clk); #1; res_valid = 1'b0;
    lookup("same_after", 9'h0C0, 1'b1, 32'h038);
    stats("same", 19, 15);

    // stats_clr wins over a same-cycle mispredict.
    @(negedge clk); stats_clr = 1'b1;
    resolve("clr", 1, 9'h0C0, 1, 0, 0, 32'h000, 1, 32'h038, 1, 32'h0C4);
    stats_clr = 1'b0;
    stats("clr", 0, 0);
    lookup("clr", 9'h0C0, 1'b1, 32'h038);
    resolve("postclr", 1, 9'h0C0, 1, 0, 1, 32'h038, 1, 32'h038, 0, 32'h000);
    stats("postclr", 1, 0);
    @(negedge clk); stats_clr = 1'b1;
    @(posedge clk); #1; stats_clr = 1'b0;
    stats("clr2", 0, 0);

    // Reset mid-run with an update in flight.
    @(negedge clk);
    res_valid = 1; res_pc = 9'h044; res_is_branch = 1; res_is_jump = 0;
    res_taken = 1; res_target = 32'h050; res_pred_taken = 0; res_pred_target = 32'h048;
    #1; rst_n = 1'b0; #1;
    lookup("midrst", 9'h0C0, 1'b0, 32'h0C4);
    chk("midrst.mispredict", {31'd0, mispredict}, 32'd1);
    chk("midrst.redirect_pc", redirect_pc, 32'h050);
    stats("midrst", 0, 0);
    @(posedge clk); #1;
    @(negedge clk); res_valid = 1'b0; #2; rst_n = 1'b1;
    lookup("postrst_a", 9'h044, 1'b0, 32'h048);
    lookup("postrst_b", 9'h0C0, 1'b0, 32'h0C4);
    resolve("postrst", 1, 9'h040, 1, 0, 1, 32'h010, 0, 32'h044, 1, 32'h010);
    lookup("postrst", 9'h040, 1'b1, 32'h010);
    stats("postrst", 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter PC_W, default 9, meaning byte-address PC width; legal range is PC_W >= IDX_W+3.
REQ-002 SHALL have parameter ENTRIES, default 16, meaning number of predictor entries; must be a power of two, 2..256; IDX_W = log2(ENTRIES).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port fetch_pc, input, PC_W bits: PC of the instruction being fetched.
REQ-006 SHALL have port pred_taken, output, 1 bit: predict taken for fetch_pc.
REQ-007 SHALL have port pred_target, output, 32 bits: predicted target, zero-extended from PC_W.
REQ-008 SHALL have ports res_valid, res_is_branch, res_is_jump, res_taken, all inputs, 1 bit each: EX-stage resolution is valid; it is a conditional branch; it is JAL/JALR; actual outcome.
REQ-009 SHALL have ports res_pc, input, PC_W bits, and res_target, input, 32 bits: resolved PC and actual target.
REQ-010 SHALL have ports res_pred_taken, input, 1 bit, and res_pred_target, input, 32 bits: prediction carried down the pipe.
REQ-011 SHALL have port mispredict, output, 1 bit: flush request.
REQ-012 SHALL have port redirect_pc, output, 32 bits: corrected fetch PC.
REQ-013 SHALL have port stats_clr, input, 1 bit: synchronous clear of the statistics counters.
REQ-014 SHALL have ports br_count and mispred_count, outputs, 32 bits each: statistics.

Function
REQ-015 SHALL compute index = pc[IDX_W+1:2] and tag = pc[PC_W-1:IDX_W+2]; each entry holds valid, tag, 2-bit counter and a PC_W-bit target.
REQ-016 SHALL drive pred_taken = valid && tag match && counter[1], combinationally from registered state, with zero-cycle latency.
REQ-017 SHALL drive pred_target = the entry target when pred_taken is 1, else fetch_pc+4; both are zero-extended.
REQ-018 SHALL define resolve = res_valid && (res_is_branch || res_is_jump); all updates and statistics are gated by resolve.
REQ-019 SHALL assert mispredict = resolve && (res_taken != res_pred_taken || (res_taken && res_target != res_pred_target)), combinationally.
REQ-020 SHALL drive redirect_pc = res_target if res_taken, else res_pc+4, zero-extended; it is 0 when mispredict is 0.
REQ-021 SHALL update an entry on a hit as follows: branches use a saturating counter (+1 if taken, -1 if not, clamped to 0..3); jumps force the counter to 3; the target is written when taken.
REQ-022 SHALL allocate on a miss only if res_taken: valid=1, tag and target written, counter=2 for a branch or 3 for a jump; a not-taken miss leaves the table unchanged.
REQ-023 SHALL use direct-mapped replacement; allocation overwrites any valid entry at that index.
REQ-024 SHALL return the pre-update value when a fetch lookup and a resolve update hit the same index in the same cycle; there is no bypass.
REQ-025 SHALL increment br_count on each resolve and mispred_count on each mispredict; both saturate at 0xFFFFFFFF and never wrap.
REQ-026 SHALL give stats_clr priority over a same-cycle increment, so the counters read 0 on the next cycle.

Reset
REQ-027 SHALL, on rst_n low, asynchronously set every entry to valid=0, counter=1 (weakly not-taken), target=0 and tag=0, and set both statistics counters to 0.
REQ-028 SHALL make all outputs reflect reset state immediately: pred_taken=0, pred_target=fetch_pc+4, and mispredict/redirect_pc depend only on res_* inputs.
REQ-029 SHALL discard any update in flight when reset is asserted mid-operation; the first update after release occurs at the first rising edge with rst_n high.

Structure
REQ-030 SHALL take the counter-state enum (SNT=0, WNT=1, WT=2, ST=3), the entry struct and the saturation helper constants from shared package bp_pkg.
REQ-031 SHALL implement the 2-bit update logic in one sub-module, bp_sat_counter (inputs: state, taken, force_st; output: next state).

Verification
REQ-032 SHALL cover this case: after reset, fetch_pc=0x040 -> pred_taken=0, pred_target=0x044.
REQ-033 SHALL cover this case: a branch at res_pc=0x040 is taken to 0x010 with pred_taken=0 -> mispredict=1 and redirect_pc=0x010; the next cycle fetch_pc=0x040 gives pred_taken=1, pred_target=0x010.
REQ-034 SHALL cover this case: the same branch is then not taken twice -> first update 2->1, so pred_taken=0; second update 1->0; three taken updates then saturate at 3.
REQ-035 SHALL cover this case: a JAL at 0x080 to 0x100 allocates with counter=3; a not-taken-style resolve cannot occur for a jump, and a hit repeats pred_target=0x100.
REQ-036 SHALL cover this case: with ENTRIES=16, PCs 0x040 and 0x0C0 alias to index 0 -> allocating 0x0C0 evicts 0x040, so fetch 0x040 gives pred_taken=0.
REQ-037 SHALL cover this case: a same-cycle lookup and update of the same index returns the old prediction; stats_clr together with a mispredict leaves both counters at 0 on the next cycle; rst_n pulsed mid-run gives all entries invalid.
